// File: rtl/imem_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words and writes them to instruction memory.
// Optional trailer checksum byte enabled by defining LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int MEM_DEPTH  = 1024,
   parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_waddr,
   output logic [DATA_WIDTH-1:0] imem_wdata,
   output logic                  core_reset,
   output logic                  load_done,
   output logic                  load_error
);

   localparam int CNT_W = ADDR_WIDTH + 1;

   typedef enum logic [2:0] {
      HDR,
      LOAD,
      WRITE,
`ifdef LOADER_CHECKSUM_EN
      CHK,
`endif
      DONE,
      ERROR
   } state_t;

   state_t                state;
   logic [1:0]            byte_cnt;
   logic [CNT_W-1:0]      word_cnt;
   logic [CNT_W-1:0]      n_words;
   logic [DATA_WIDTH-1:0] shift_q;
   logic                  fire;
   logic [DATA_WIDTH-1:0] word_next;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]            csum;
`endif

   assign fire      = byte_valid && byte_ready;
   // New bytes enter at the top so the first byte ends up in bits [7:0].
   assign word_next = {byte_data, shift_q[DATA_WIDTH-1:8]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= HDR;
         byte_cnt   <= 2'd0;
         word_cnt   <= '0;
         n_words    <= '0;
         shift_q    <= '0;
         byte_ready <= 1'b0;
         imem_we    <= 1'b0;
         imem_waddr <= '0;
         imem_wdata <= '0;
         core_reset <= 1'b1;
         load_done  <= 1'b0;
         load_error <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum       <= 8'h00;
`endif
      end else begin
         case (state)
            HDR: begin
               byte_ready <= 1'b1;
               if (fire) begin
                  shift_q  <= word_next;
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     byte_cnt <= 2'd0;
                     if (word_next == '0) begin
`ifdef LOADER_CHECKSUM_EN
                        state      <= CHK;
`else
                        state      <= DONE;
                        byte_ready <= 1'b0;
                        load_done  <= 1'b1;
                        core_reset <= 1'b0;
`endif
                     end else if (word_next > DATA_WIDTH'(MEM_DEPTH)) begin
                        state      <= ERROR;
                        byte_ready <= 1'b0;
                        load_error <= 1'b1;
                     end else begin
                        state      <= LOAD;
                        n_words    <= word_next[CNT_W-1:0];
                        word_cnt   <= '0;
                        imem_waddr <= '0;
                     end
                  end
               end
            end

            LOAD: begin
               if (fire) begin
                  shift_q  <= word_next;
                  byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                  csum     <= csum ^ byte_data;
`endif
                  if (byte_cnt == 2'd3) begin
                     byte_cnt   <= 2'd0;
                     byte_ready <= 1'b0;
                     imem_we    <= 1'b1;
                     imem_wdata <= word_next;
                     word_cnt   <= word_cnt + CNT_W'(1);
                     state      <= WRITE;
                  end
               end
            end

            // Single strobe cycle; the address only advances when another word follows.
            WRITE: begin
               imem_we <= 1'b0;
               if (word_cnt == n_words) begin
`ifdef LOADER_CHECKSUM_EN
                  state      <= CHK;
                  byte_ready <= 1'b1;
`else
                  state      <= DONE;
                  load_done  <= 1'b1;
                  core_reset <= 1'b0;
`endif
               end else begin
                  imem_waddr <= imem_waddr + ADDR_WIDTH'(1);
                  byte_ready <= 1'b1;
                  state      <= LOAD;
               end
            end

`ifdef LOADER_CHECKSUM_EN
            CHK: begin
               if (fire) begin
                  byte_ready <= 1'b0;
                  if (byte_data == csum) begin
                     state      <= DONE;
                     load_done  <= 1'b1;
                     core_reset <= 1'b0;
                  end else begin
                     state      <= ERROR;
                     load_error <= 1'b1;
                  end
               end
            end
`endif

            DONE: begin
               byte_ready <= 1'b0;
               load_done  <= 1'b1;
               core_reset <= 1'b0;
            end

            ERROR: begin
               byte_ready <= 1'b0;
               load_error <= 1'b1;
            end

            default: begin
               state      <= ERROR;
               byte_ready <= 1'b0;
               load_error <= 1'b1;
            end
         endcase
      end
   end

endmodule
